// File: rtl/mq_interval_update.sv
// rtl/mq_interval_update.sv - MQ coder interval update, renormalisation and byte-out stage
// Holds the A/C/CT/B coder registers and the per-context {index, MPS} table.
module mq_interval_update #(
  parameter int NUM_CX = 19
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [4:0]  CX_in,
  input  logic [15:0] Qe_value,
  input  logic [5:0]  NMPS,
  input  logic [5:0]  NLPS,
  input  logic [3:0]  LZ0,
  input  logic [5:0]  QeIndex_forward,
  input  logic        MPS_coding,
  input  logic        MPS_update,
  input  logic [4:0]  rd_cx,
  output logic [5:0]  rd_index,
  output logic        rd_mps,
  output logic [5:0]  SelIndex_IU,
  output logic        MPS_update_IU,
  output logic [4:0]  CX_IU,
  output logic        valid_IU,
  output logic        byte_valid,
  output logic [7:0]  byte_out,
  output logic [15:0] A_reg,
  output logic [27:0] C_reg,
  output logic [3:0]  CT_reg,
  output logic [7:0]  B_reg
);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_BYTEOUT} state_t;

  localparam logic [4:0] CX_LIMIT = 5'(NUM_CX);

  function automatic logic [NUM_CX-1:0][6:0] tbl_init();
    tbl_init     = '0;
    tbl_init[0]  = {6'd4, 1'b0};
    tbl_init[17] = {6'd46, 1'b0};
    tbl_init[18] = {6'd3, 1'b0};
  endfunction

  localparam logic [NUM_CX-1:0][6:0] TBL_INIT = tbl_init();

  function automatic logic [3:0] lzc16(input logic [15:0] v);
    lzc16 = 4'd15;
    for (int i = 0; i < 16; i++) begin
      if (v[i]) lzc16 = 4'(15 - i);
    end
  endfunction

  state_t                   r_state;
  logic [15:0]              r_a;
  logic [27:0]              r_c;
  logic [3:0]               r_ct;
  logic [7:0]               r_b;
  logic                     r_first;
  logic [3:0]               r_rem;
  logic [NUM_CX-1:0][6:0]   r_tbl;
  logic [5:0]               r_sel_index;
  logic                     r_sel_mps;
  logic [4:0]               r_cx_iu;
  logic                     r_valid_iu;
  logic                     r_byte_valid;
  logic [7:0]               r_byte_out;

  logic [15:0] w_an;
  logic [15:0] w_new_a;
  logic [27:0] w_new_c;
  logic [5:0]  w_new_idx;
  logic [3:0]  w_n;
  logic [3:0]  w_s;
  logic [3:0]  w_ct_s;
  logic [3:0]  w_rem_s;
  logic [7:0]  w_b_inc;
  logic [27:0] w_c_clr;
  logic [7:0]  w_emit;
  logic [7:0]  w_bo_b;
  logic [27:0] w_bo_c;
  logic [3:0]  w_bo_ct;
  logic [6:0]  w_rd_ent;
  logic        w_unused;

  // LZ0 is carried for the upstream interface only; the shift count comes from the new A.
  assign w_unused = ^LZ0;

  assign w_an = r_a - Qe_value;

  always_comb begin
    w_new_a   = r_a;
    w_new_c   = r_c;
    w_new_idx = QeIndex_forward;
    if (MPS_coding) begin
      if (w_an[15]) begin
        w_new_a = w_an;
        w_new_c = r_c + {12'd0, Qe_value};
      end else begin
        w_new_idx = NMPS;
        if (w_an < Qe_value) begin
          w_new_a = Qe_value;
        end else begin
          w_new_a = w_an;
          w_new_c = r_c + {12'd0, Qe_value};
        end
      end
    end else begin
      w_new_idx = NLPS;
      if (w_an < Qe_value) begin
        w_new_a = w_an;
        w_new_c = r_c + {12'd0, Qe_value};
      end else begin
        w_new_a = Qe_value;
      end
    end
  end

  assign w_n     = lzc16(w_new_a);
  assign w_s     = (r_rem < r_ct) ? r_rem : r_ct;
  assign w_ct_s  = r_ct - w_s;
  assign w_rem_s = r_rem - w_s;

  // Carry into B: the incremented byte is the one emitted, and C loses its carry bit.
  assign w_b_inc = r_b + 8'd1;
  assign w_c_clr = {1'b0, r_c[26:0]};

  always_comb begin
    w_emit  = r_b;
    w_bo_b  = r_c[26:19];
    w_bo_c  = r_c & 28'h007FFFF;
    w_bo_ct = 4'd8;
    if (r_b == 8'hFF) begin
      w_bo_b  = r_c[27:20];
      w_bo_c  = r_c & 28'h00FFFFF;
      w_bo_ct = 4'd7;
    end else if (r_c[27]) begin
      w_emit = w_b_inc;
      if (w_b_inc == 8'hFF) begin
        w_bo_b  = w_c_clr[27:20];
        w_bo_c  = w_c_clr & 28'h00FFFFF;
        w_bo_ct = 4'd7;
      end else begin
        w_bo_b  = w_c_clr[26:19];
        w_bo_c  = w_c_clr & 28'h007FFFF;
        w_bo_ct = 4'd8;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || (start && r_state == S_IDLE)) begin
      r_state      <= S_IDLE;
      r_a          <= 16'h8000;
      r_c          <= '0;
      r_ct         <= 4'd12;
      r_b          <= '0;
      r_first      <= 1'b1;
      r_rem        <= '0;
      r_tbl        <= TBL_INIT;
      r_sel_index  <= '0;
      r_sel_mps    <= 1'b0;
      r_cx_iu      <= '0;
      r_valid_iu   <= 1'b0;
      r_byte_valid <= 1'b0;
      r_byte_out   <= '0;
    end else begin
      r_valid_iu   <= 1'b0;
      r_byte_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_a         <= w_new_a;
            r_c         <= w_new_c;
            if (CX_in < CX_LIMIT) r_tbl[CX_in] <= {w_new_idx, MPS_update};
            r_sel_index <= w_new_idx;
            r_sel_mps   <= MPS_update;
            r_cx_iu     <= CX_in;
            r_valid_iu  <= 1'b1;
            if (w_n != 4'd0) begin
              r_rem   <= w_n;
              r_state <= S_SHIFT;
            end
          end
        end
        S_SHIFT: begin
          r_a   <= r_a << w_s;
          r_c   <= r_c << w_s;
          r_ct  <= w_ct_s;
          r_rem <= w_rem_s;
          if (w_ct_s == 4'd0)       r_state <= S_BYTEOUT;
          else if (w_rem_s == 4'd0) r_state <= S_IDLE;
        end
        S_BYTEOUT: begin
          r_b  <= w_bo_b;
          r_c  <= w_bo_c;
          r_ct <= w_bo_ct;
          // The very first byte-out only primes B; nothing real has been coded into it yet.
          if (r_first) begin
            r_first <= 1'b0;
          end else begin
            r_byte_valid <= 1'b1;
            r_byte_out   <= w_emit;
          end
          r_state <= (r_rem == 4'd0) ? S_IDLE : S_SHIFT;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign w_rd_ent      = (rd_cx < CX_LIMIT) ? r_tbl[rd_cx] : 7'd0;
  assign rd_index      = w_rd_ent[6:1];
  assign rd_mps        = w_rd_ent[0];
  assign in_ready      = (r_state == S_IDLE);
  assign SelIndex_IU   = r_sel_index;
  assign MPS_update_IU = r_sel_mps;
  assign CX_IU         = r_cx_iu;
  assign valid_IU      = r_valid_iu;
  assign byte_valid    = r_byte_valid;
  assign byte_out      = r_byte_out;
  assign A_reg         = r_a;
  assign C_reg         = r_c;
  assign CT_reg        = r_ct;
  assign B_reg         = r_b;

endmodule

// File: tb/tb_mq_interval_update.sv
// tb/tb_mq_interval_update.sv - directed bench for mq_interval_update
// Each task drives one scenario and checks against hand-derived coder values.
module tb_mq_interval_update;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [4:0]  CX_in = '0;
  logic [15:0] Qe_value = '0;
  logic [5:0]  NMPS = '0;
  logic [5:0]  NLPS = '0;
  logic [3:0]  LZ0 = '0;
  logic [5:0]  QeIndex_forward = '0;
  logic        MPS_coding = 1'b0;
  logic        MPS_update = 1'b0;
  logic [4:0]  rd_cx = '0;
  logic [5:0]  rd_index;
  logic        rd_mps;
  logic [5:0]  SelIndex_IU;
  logic        MPS_update_IU;
  logic [4:0]  CX_IU;
  logic        valid_IU;
  logic        byte_valid;
  logic [7:0]  byte_out;
  logic [15:0] A_reg;
  logic [27:0] C_reg;
  logic [3:0]  CT_reg;
  logic [7:0]  B_reg;

  int n_cmp = 0;
  int n_bad = 0;

  mq_interval_update #(.NUM_CX(19)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .CX_in(CX_in), .Qe_value(Qe_value), .NMPS(NMPS), .NLPS(NLPS), .LZ0(LZ0),
    .QeIndex_forward(QeIndex_forward), .MPS_coding(MPS_coding), .MPS_update(MPS_update),
    .rd_cx(rd_cx), .rd_index(rd_index), .rd_mps(rd_mps),
    .SelIndex_IU(SelIndex_IU), .MPS_update_IU(MPS_update_IU), .CX_IU(CX_IU), .valid_IU(valid_IU),
    .byte_valid(byte_valid), .byte_out(byte_out),
    .A_reg(A_reg), .C_reg(C_reg), .CT_reg(CT_reg), .B_reg(B_reg)
  );

  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Presents one decision for a single cycle; returns #1 after the accepting edge.
  task automatic dec(input logic [4:0] cx, input logic [15:0] q, input logic [5:0] nm,
                     input logic [5:0] nl, input logic [5:0] idx, input logic mc, input logic mu);
    @(negedge clk);
    CX_in = cx; Qe_value = q; NMPS = nm; NLPS = nl; QeIndex_forward = idx;
    MPS_coding = mc; MPS_update = mu; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (A_reg !== 16'h8000) begin n_bad++; $display("FAIL reset_A got %h want 8000", A_reg); end
    n_cmp++; if (C_reg !== 28'h0) begin n_bad++; $display("FAIL reset_C got %h want 0", C_reg); end
    n_cmp++; if (CT_reg !== 4'd12) begin n_bad++; $display("FAIL reset_CT got %0d want 12", CT_reg); end
    n_cmp++; if (B_reg !== 8'h00) begin n_bad++; $display("FAIL reset_B got %h want 00", B_reg); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    n_cmp++; if (byte_valid !== 1'b0) begin n_bad++; $display("FAIL reset_byte_valid got %b want 0", byte_valid); end
    n_cmp++; if (valid_IU !== 1'b0) begin n_bad++; $display("FAIL reset_valid_IU got %b want 0", valid_IU); end
    rd_cx = 5'd17; #1;
    n_cmp++; if (rd_index !== 6'd46) begin n_bad++; $display("FAIL reset_tbl17 got %0d want 46", rd_index); end
    rd_cx = 5'd0; #1;
    n_cmp++; if (rd_index !== 6'd4) begin n_bad++; $display("FAIL reset_tbl0 got %0d want 4", rd_index); end
    rd_cx = 5'd18; #1;
    n_cmp++; if (rd_index !== 6'd3) begin n_bad++; $display("FAIL reset_tbl18 got %0d want 3", rd_index); end
    rd_cx = 5'd5; #1;
    n_cmp++; if ({rd_index, rd_mps} !== 7'd0) begin n_bad++; $display("FAIL reset_tbl5 got %0d/%b want 0/0", rd_index, rd_mps); end
  endtask

  task automatic test_mps();
    do_reset();
    dec(5'd17, 16'h5601, 6'd46, 6'd20, 6'd46, 1'b1, 1'b0);
    n_cmp++; if (valid_IU !== 1'b1) begin n_bad++; $display("FAIL mps_valid_IU got %b want 1", valid_IU); end
    n_cmp++; if (SelIndex_IU !== 6'd46) begin n_bad++; $display("FAIL mps_sel got %0d want 46", SelIndex_IU); end
    n_cmp++; if (CX_IU !== 5'd17) begin n_bad++; $display("FAIL mps_cx got %0d want 17", CX_IU); end
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL mps_busy got %b want 0", in_ready); end
    cyc(1);
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL mps_ready got %b want 1", in_ready); end
    n_cmp++; if (valid_IU !== 1'b0) begin n_bad++; $display("FAIL mps_valid_pulse got %b want 0", valid_IU); end
    n_cmp++; if ({A_reg, C_reg, CT_reg} !== {16'hAC02, 28'h0, 4'd11}) begin n_bad++; $display("FAIL mps1_ACCT got %h/%h/%0d want AC02/0/11", A_reg, C_reg, CT_reg); end
    dec(5'd17, 16'h5601, 6'd46, 6'd20, 6'd46, 1'b1, 1'b0);
    cyc(1);
    n_cmp++; if ({A_reg, C_reg, CT_reg} !== {16'hAC02, 28'hAC02, 4'd10}) begin n_bad++; $display("FAIL mps2_ACCT got %h/%h/%0d want AC02/AC02/10", A_reg, C_reg, CT_reg); end
    // A - Qe keeps bit 15: no renormalisation, index held.
    dec(5'd17, 16'h1000, 6'd10, 6'd20, 6'd46, 1'b1, 1'b0);
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL mps_n0_ready got %b want 1", in_ready); end
    n_cmp++; if ({A_reg, C_reg, CT_reg} !== {16'h9C02, 28'hBC02, 4'd10}) begin n_bad++; $display("FAIL mps_n0_ACCT got %h/%h/%0d want 9C02/BC02/10", A_reg, C_reg, CT_reg); end
    n_cmp++; if (SelIndex_IU !== 6'd46) begin n_bad++; $display("FAIL mps_n0_sel got %0d want 46", SelIndex_IU); end
  endtask

  task automatic test_lps();
    do_reset();
    dec(5'd5, 16'h5601, 6'd2, 6'd1, 6'd0, 1'b0, 1'b1);
    n_cmp++; if ({SelIndex_IU, MPS_update_IU, CX_IU} !== {6'd1, 1'b1, 5'd5}) begin n_bad++; $display("FAIL lps_iu got %0d/%b/%0d want 1/1/5", SelIndex_IU, MPS_update_IU, CX_IU); end
    cyc(1);
    n_cmp++; if ({A_reg, C_reg, CT_reg} !== {16'hA7FC, 28'h15804, 4'd10}) begin n_bad++; $display("FAIL lps_ACCT got %h/%h/%0d want A7FC/15804/10", A_reg, C_reg, CT_reg); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL lps_ready got %b want 1", in_ready); end
    rd_cx = 5'd5; #1;
    n_cmp++; if ({rd_index, rd_mps} !== {6'd1, 1'b1}) begin n_bad++; $display("FAIL lps_tbl5 got %0d/%b want 1/1", rd_index, rd_mps); end
  endtask

  task automatic test_long_shift();
    int nbv;
    do_reset();
    nbv = 0;
    dec(5'd0, 16'h0001, 6'd0, 6'd45, 6'd4, 1'b0, 1'b0);
    for (int k = 1; k <= 3; k++) begin
      n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL long_busy_c%0d got %b want 0", k, in_ready); end
      cyc(1);
      if (byte_valid) nbv++;
      if (k == 1) begin
        n_cmp++; if ({A_reg, CT_reg} !== {16'h1000, 4'd0}) begin n_bad++; $display("FAIL long_shift12 got %h/%0d want 1000/0", A_reg, CT_reg); end
      end
      if (k == 2) begin
        n_cmp++; if ({CT_reg, B_reg} !== {4'd8, 8'h00}) begin n_bad++; $display("FAIL long_byteout got %0d/%h want 8/00", CT_reg, B_reg); end
      end
    end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL long_ready got %b want 1", in_ready); end
    n_cmp++; if ({A_reg, CT_reg} !== {16'h8000, 4'd5}) begin n_bad++; $display("FAIL long_final got %h/%0d want 8000/5", A_reg, CT_reg); end
    cyc(1);
    if (byte_valid) nbv++;
    n_cmp++; if (nbv !== 0) begin n_bad++; $display("FAIL long_suppressed got %0d strobes want 0", nbv); end
  endtask

  task automatic test_byte_ff();
    do_reset();
    dec(5'd1, 16'h7F80, 6'd0, 6'd2, 6'd0, 1'b0, 1'b0);
    cyc(1);
    n_cmp++; if ({A_reg, C_reg, CT_reg} !== {16'h8000, 28'h7F8000, 4'd4}) begin n_bad++; $display("FAIL ff_setup got %h/%h/%0d want 8000/7F8000/4", A_reg, C_reg, CT_reg); end
    dec(5'd1, 16'h0001, 6'd0, 6'd3, 6'd2, 1'b0, 1'b0);
    cyc(2);
    n_cmp++; if ({B_reg, CT_reg, byte_valid} !== {8'hFF, 4'd8, 1'b0}) begin n_bad++; $display("FAIL ff_B got %h/%0d/%b want FF/8/0", B_reg, CT_reg, byte_valid); end
    cyc(2);
    n_cmp++; if ({byte_valid, byte_out} !== {1'b1, 8'hFF}) begin n_bad++; $display("FAIL ff_emit got %b/%h want 1/FF", byte_valid, byte_out); end
    n_cmp++; if ({CT_reg, B_reg} !== {4'd7, 8'h00}) begin n_bad++; $display("FAIL ff_CT got %0d/%h want 7/00", CT_reg, B_reg); end
    cyc(1);
    n_cmp++; if ({byte_valid, in_ready, A_reg, CT_reg} !== {1'b0, 1'b1, 16'h8000, 4'd4}) begin n_bad++; $display("FAIL ff_end got %b/%b/%h/%0d want 0/1/8000/4", byte_valid, in_ready, A_reg, CT_reg); end
  endtask

  task automatic test_carry();
    do_reset();
    dec(5'd2, 16'h7F7F, 6'd0, 6'd1, 6'd0, 1'b0, 1'b0);
    cyc(1);
    n_cmp++; if ({A_reg, C_reg, CT_reg} !== {16'h8100, 28'h7F7F00, 4'd4}) begin n_bad++; $display("FAIL carry_s1 got %h/%h/%0d want 8100/7F7F00/4", A_reg, C_reg, CT_reg); end
    dec(5'd2, 16'h0800, 6'd0, 6'd1, 6'd1, 1'b0, 1'b0);
    cyc(2);
    n_cmp++; if ({B_reg, C_reg, CT_reg, in_ready} !== {8'hFE, 28'h7F000, 4'd8, 1'b1}) begin n_bad++; $display("FAIL carry_s2 got %h/%h/%0d/%b want FE/7F000/8/1", B_reg, C_reg, CT_reg, in_ready); end
    dec(5'd2, 16'h7000, 6'd0, 6'd1, 6'd1, 1'b0, 1'b0);
    cyc(1);
    n_cmp++; if ({A_reg, C_reg, CT_reg} !== {16'h8000, 28'h430000, 4'd5}) begin n_bad++; $display("FAIL carry_s3 got %h/%h/%0d want 8000/430000/5", A_reg, C_reg, CT_reg); end
    dec(5'd2, 16'h0400, 6'd0, 6'd1, 6'd1, 1'b0, 1'b0);
    cyc(2);
    n_cmp++; if ({byte_valid, byte_out, CT_reg} !== {1'b1, 8'hFF, 4'd7}) begin n_bad++; $display("FAIL carry_emit got %b/%h/%0d want 1/FF/7", byte_valid, byte_out, CT_reg); end
    n_cmp++; if ({B_reg, C_reg, in_ready} !== {8'h06, 28'h0, 1'b1}) begin n_bad++; $display("FAIL carry_state got %h/%h/%b want 06/0/1", B_reg, C_reg, in_ready); end
  endtask

  task automatic test_reset_midshift();
    do_reset();
    dec(5'd3, 16'h0001, 6'd0, 6'd45, 6'd0, 1'b0, 1'b1);
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL rst_mid_busy got %b want 0", in_ready); end
    rst_n = 1'b0;
    cyc(1);
    rd_cx = 5'd3; #1;
    n_cmp++; if ({in_ready, A_reg, C_reg, CT_reg, B_reg} !== {1'b1, 16'h8000, 28'h0, 4'd12, 8'h00}) begin n_bad++; $display("FAIL rst_mid_regs got %b/%h/%h/%0d/%h want 1/8000/0/12/00", in_ready, A_reg, C_reg, CT_reg, B_reg); end
    n_cmp++; if ({valid_IU, SelIndex_IU, MPS_update_IU, CX_IU} !== 13'd0) begin n_bad++; $display("FAIL rst_mid_iu got %b/%0d/%b/%0d want 0/0/0/0", valid_IU, SelIndex_IU, MPS_update_IU, CX_IU); end
    n_cmp++; if ({rd_index, rd_mps} !== 7'd0) begin n_bad++; $display("FAIL rst_mid_tbl got %0d/%b want 0/0", rd_index, rd_mps); end
    rst_n = 1'b1;
  endtask

  task automatic test_start_busy();
    do_reset();
    dec(5'd4, 16'h0001, 6'd0, 6'd45, 6'd0, 1'b0, 1'b0);
    start = 1'b1;
    CX_in = 5'd6; Qe_value = 16'h4000; MPS_coding = 1'b1; in_valid = 1'b1;
    cyc(1);
    start = 1'b0; in_valid = 1'b0;
    cyc(2);
    n_cmp++; if ({in_ready, A_reg, CT_reg} !== {1'b1, 16'h8000, 4'd5}) begin n_bad++; $display("FAIL start_busy got %b/%h/%0d want 1/8000/5", in_ready, A_reg, CT_reg); end
    n_cmp++; if ({SelIndex_IU, CX_IU} !== {6'd45, 5'd4}) begin n_bad++; $display("FAIL start_busy_iu got %0d/%0d want 45/4", SelIndex_IU, CX_IU); end
    @(negedge clk);
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    rd_cx = 5'd4; #1;
    n_cmp++; if ({A_reg, CT_reg, SelIndex_IU, rd_index} !== {16'h8000, 4'd12, 6'd0, 6'd0}) begin n_bad++; $display("FAIL start_idle got %h/%0d/%0d/%0d want 8000/12/0/0", A_reg, CT_reg, SelIndex_IU, rd_index); end
  endtask

  initial begin
    test_reset();
    test_mps();
    test_lps();
    test_long_shift();
    test_byte_ff();
    test_carry();
    test_reset_midshift();
    test_start_busy();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/mq_interval_update.md
# mq_interval_update

Interval-update (IU) stage of the MQ arithmetic coder, directly downstream of the probability-estimation stage. It consumes one coded decision per accepted transfer: Qe, NMPS, NLPS, LZ0, current index, MPS_coding and MPS_update. It updates the A/C registers, writes the new state back to the 19-entry context table, renormalises with a shift/byte-out state machine, and emits compressed bytes. It also returns the post-update index and MPS to the upstream stage for back-to-back forwarding.

## Interface
- NUM_CX, 19, number of contexts in the state table.
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- start  in  1  one-cycle pulse; reinitialises the coder to its reset values. Only sampled while in_ready=1.
- in_valid  in  1  decision valid.
- in_ready  out  1  high only in IDLE.
- CX_in  in  5  context of the decision.
- Qe_value  in  16  Qe for the current index.
- NMPS, NLPS  in  6 each  next-index candidates.
- LZ0  in  4  leading zeros of Qe. Informational only; the shift count is computed internally.
- QeIndex_forward  in  6  current index.
- MPS_coding  in  1  1 = decision equals MPS.
- MPS_update  in  1  MPS after a switch check.
- rd_cx  in  5  context-table read address.
- rd_index  out  6  combinational read data, index.
- rd_mps  out  1  combinational read data, MPS.
- SelIndex_IU  out  6  registered index written by the last accepted decision.
- MPS_update_IU  out  1  registered MPS written by the last accepted decision.
- CX_IU  out  5  registered context of the last accepted decision.
- valid_IU  out  1  one-cycle pulse in the cycle after an accept.
- byte_valid  out  1  one-cycle strobe.
- byte_out  out  8  emitted byte; there is no backpressure.
- A_reg  out  16  A register, exposed for the flush block.
- C_reg  out  28  C register, exposed for the flush block.
- CT_reg  out  4  CT counter, exposed for the flush block.
- B_reg  out  8  pending byte B, exposed for the flush block.

## Operation
- Reset or start values:
  - A=0x8000, C=0, CT=12, B=0, first_byte=1, state=IDLE.
  - valid_IU=0, byte_valid=0, byte_out=0, SelIndex_IU=0, MPS_update_IU=0, CX_IU=0.
  - Context table: CX0 index 4; CX17 index 46; CX18 index 3; all other contexts index 0. All MPS=0.
- Accept happens on in_valid & in_ready. Let An = A − Qe_value (16-bit).
- MPS_coding=1:
  - If An[15]=1: C += Qe. Index is unchanged (QeIndex_forward).
  - Otherwise: if An < Qe then A = Qe, else A = An and C += Qe. Index becomes NMPS.
- MPS_coding=0:
  - If An < Qe: A = An and C += Qe. Otherwise A = Qe.
  - Index becomes NLPS.
- On the accept edge:
  - Write {new index, MPS_update} to table[CX_in].
  - Register SelIndex_IU, MPS_update_IU and CX_IU.
- Shift count n = leading-zero count of the new A. n is never 16, because A is always nonzero.
  - n=0: stay in IDLE.
  - Otherwise: rem=n, go to SHIFT.
- SHIFT:
  - s = min(rem, CT). A <<= s and C <<= s (28-bit, upper bits discarded). CT −= s, rem −= s.
  - If CT=0 go to BYTEOUT; else if rem=0 go to IDLE; else stay in SHIFT.
- BYTEOUT (T.800 BYTEOUT procedure):
  - B=0xFF: emit B; B = C[27:20]; C &= 0xFFFFF; CT = 7.
  - Else C[27]=0: emit B; B = C[26:19]; C &= 0x7FFFF; CT = 8.
  - Else: B += 1 and C[27] is cleared.
    - If B became 0xFF: emit B; B = C[27:20]; C &= 0xFFFFF; CT = 7.
    - Otherwise: emit B; B = C[26:19]; C &= 0x7FFFF; CT = 8.
  - "Emit" asserts byte_valid for one cycle, except when first_byte=1. In that case the byte is suppressed and first_byte is cleared.
  - Next state: IDLE if rem=0, else SHIFT.
- The table read port reflects a write from the following cycle onward. The upstream stage forwards SelIndex_IU/MPS_update_IU when valid_IU=1 and CX_IU matches its context.

## Timing
- Accept to in_ready re-high:
  - 1 cycle for n=0.
  - 2 cycles if no byte-out is needed.
  - Plus 1 cycle per SHIFT and per BYTEOUT visit.
- valid_IU is high exactly in the cycle after the accept.
- byte_valid is registered, asserted in the cycle after the BYTEOUT state.
- start while not IDLE is ignored.
- rst_n=0 in any state returns the block to IDLE with reset values on the next edge. A pending byte is dropped.
- in_valid is ignored while in_ready=0, and any inputs presented then are dropped.

## Test plan
- Reset -> A_reg=0x8000, C_reg=0, CT_reg=12, in_ready=1, byte_valid=0, rd_cx=17 gives rd_index=46, rd_cx=0 gives rd_index=4.
- From reset, MPS with Qe=0x5601, index 46, NMPS=46 -> A=0xAC02, C=0, CT=11, SelIndex_IU=46, valid_IU pulse. Repeat the same decision -> A=0xAC02, C=0xAC02, CT=10.
- From reset, LPS on CX5 with Qe=0x5601, index 0, NLPS=1, MPS_update=1 -> A=0xA7FC, C=0x15804, CT=10. Then rd_cx=5 gives rd_index=1 and rd_mps=1.
- From reset, LPS with Qe=0x0001, NLPS=45 (A=Qe, n=15) -> SHIFT(12), BYTEOUT with byte suppressed and CT=8, SHIFT(3). Final A=0x8000, CT=5. in_ready is high again 4 cycles after the accept; byte_valid never asserts.
- Drive decisions until B_reg=0xFF, then force the next byte-out -> byte_out=0xFF, CT=7. Repeat with a carry (C[27]=1, B=0xFE) -> emitted byte 0xFF and CT=7.
- Assert rst_n=0 during SHIFT -> next cycle in_ready=1 with all reset values. Assert start while busy -> it has no effect.
